// File: rtl/combiner_n.sv
// rtl/combiner_n.sv - joins SIZE valid/ready lanes into one concatenated output beat
module combiner_n #(
  parameter int    SIZE  = 8,
  parameter int    WIDTH = 32,
  parameter string BURST = "yes"
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [SIZE-1:0]       iValid_AM,
  output logic [SIZE-1:0]       oReady_AM,
  input  logic [SIZE*WIDTH-1:0] iData_AM,
  output logic                  oValid_BM,
  input  logic                  iReady_BM,
  output logic [SIZE*WIDTH-1:0] oData_BM
);

  // In burst mode a slot being joined this cycle may take its next word at once
  localparam bit burstMode = (BURST == "yes");

  logic [SIZE-1:0]             full;
  logic [SIZE-1:0][WIDTH-1:0]  slot;
  logic                        ovld;
  logic [SIZE*WIDTH-1:0]       odata;
  logic                        joinNow;
  logic [SIZE-1:0]             acc;

  // A beat forms when every lane holds a word and the output register is free or draining;
  // ready is therefore combinational on iReady_BM in burst mode
  always_comb begin
    joinNow   = (&full) && (!ovld || iReady_BM);
    oReady_AM = '0;
    for (int i = 0; i < SIZE; i++) begin
      oReady_AM[i] = !full[i] || (burstMode && joinNow);
    end
    acc = iValid_AM & oReady_AM;
  end

  // Capture per-lane words, empty slots on join, and load the registered output beat
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      full  <= '0;
      slot  <= '0;
      ovld  <= 1'b0;
      odata <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (acc[i]) begin
          slot[i] <= iData_AM[i*WIDTH +: WIDTH];
          full[i] <= 1'b1;
        end else if (joinNow) begin
          full[i] <= 1'b0;
        end
      end
      if (joinNow) begin
        ovld  <= 1'b1;
        odata <= slot;
      end else if (iReady_BM) begin
        ovld  <= 1'b0;
      end
    end
  end

  assign oValid_BM = ovld;
  assign oData_BM  = odata;

endmodule

// File: tb/tb_combiner_n.sv
// tb/tb_combiner_n.sv - randomized and directed self-checking bench for combiner_n
module tb_combiner_n;
  localparam int LOGN = 4096;
  localparam int NRND = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rB;
  logic [3:0]  vIn [2];
  logic [31:0] dIn [2];
  logic [3:0]  rdyY, rdyN;
  logic        ovY, ovN;
  logic [31:0] odY, odN;

  combiner_n #(.SIZE(4), .WIDTH(8), .BURST("yes")) dutY (
    .iCLK(clk), .iRST(rst), .iValid_AM(vIn[0]), .oReady_AM(rdyY), .iData_AM(dIn[0]),
    .oValid_BM(ovY), .iReady_BM(rB), .oData_BM(odY));

  combiner_n #(.SIZE(4), .WIDTH(8), .BURST("no")) dutN (
    .iCLK(clk), .iRST(rst), .iValid_AM(vIn[1]), .oReady_AM(rdyN), .iData_AM(dIn[1]),
    .oValid_BM(ovN), .iReady_BM(rB), .oData_BM(odN));

  // Sources: words each lane still has to send; model: words captured per lane and the pending beat
  logic [7:0]  srcQ [2][4][$];
  logic [7:0]  lq   [2][4][$];
  logic        mOv  [2];
  logic [31:0] mOd  [2];
  logic [3:0]  vEn;
  int          cyc;
  bit          chkEn;
  int          nChk, nPass;
  logic [31:0] beatD [2][$];
  int          beatC [2][$];
  logic [3:0]  rdyLog [2][LOGN];
  logic        vldLog [2][LOGN];
  logic [31:0] datLog [2][LOGN];
  logic [7:0]  sent [4][NRND];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic bit mJoin(int d);
    bit all = 1'b1;
    for (int i = 0; i < 4; i++) if (lq[d][i].size() == 0) all = 1'b0;
    return all && (!mOv[d] || rB);
  endfunction

  function automatic logic [3:0] mReady(int d);
    logic [3:0] r;
    bit j = mJoin(d);
    for (int i = 0; i < 4; i++) r[i] = (lq[d][i].size() == 0) || (d == 0 && j);
    return r;
  endfunction

  function automatic bit idle();
    bit b = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (mOv[d]) b = 1'b0;
      for (int i = 0; i < 4; i++)
        if (srcQ[d][i].size() != 0 || lq[d][i].size() != 0) b = 1'b0;
    end
    return b;
  endfunction

  function automatic logic [31:0] beatOf(int base, int n);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[i*8 +: 8] = 8'(base + 16*i + n);
    return b;
  endfunction

  task automatic drive();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        vIn[d][i] = vEn[i] && (srcQ[d][i].size() != 0);
        dIn[d][i*8 +: 8] = vIn[d][i] ? srcQ[d][i][0] : 8'($urandom);
      end
  endtask

  // One clock: present inputs, then advance the model across the rising edge
  task automatic tick();
    logic [3:0]  r [2];
    bit          j [2];
    logic [31:0] beat;
    drive();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      r[d] = mReady(d);
      j[d] = mJoin(d);
    end
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) lq[d][i].delete();
        mOv[d] = 1'b0;
        mOd[d] = '0;
      end else begin
        if (j[d]) begin
          for (int i = 0; i < 4; i++) beat[i*8 +: 8] = lq[d][i].pop_front();
          mOv[d] = 1'b1;
          mOd[d] = beat;
        end else if (rB) begin
          mOv[d] = 1'b0;
        end
        for (int i = 0; i < 4; i++)
          if (vIn[d][i] && r[d][i]) lq[d][i].push_back(srcQ[d][i].pop_front());
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clearLogs();
    for (int d = 0; d < 2; d++) begin
      beatD[d].delete();
      beatC[d].delete();
    end
  endtask

  task automatic clearSrc();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) srcQ[d][i].delete();
  endtask

  task automatic drain(int bound);
    int n = 0;
    vEn = 4'hF;
    rB  = 1'b1;
    while (!idle() && n < bound) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(idle()), 32'd1);
  endtask

  // Compare process: DUT outputs against the model every cycle, plus per-cycle logs
  initial forever begin
    @(negedge clk);
    if (chkEn) begin
      for (int d = 0; d < 2; d++) begin
        logic        ov;
        logic [31:0] od;
        logic [3:0]  rdy;
        ov  = (d == 0) ? ovY  : ovN;
        od  = (d == 0) ? odY  : odN;
        rdy = (d == 0) ? rdyY : rdyN;
        chk($sformatf("valid_d%0d", d), 32'(ov), 32'(mOv[d]));
        if (mOv[d]) chk($sformatf("data_d%0d", d), od, mOd[d]);
        chk($sformatf("ready_d%0d", d), 32'(rdy), 32'(mReady(d)));
        if (cyc < LOGN) begin
          rdyLog[d][cyc] = rdy;
          vldLog[d][cyc] = ov;
          datLog[d][cyc] = od;
        end
        if (ov === 1'b1 && rB) begin
          beatD[d].push_back(od);
          beatC[d].push_back(cyc);
        end
      end
    end
  end

  initial begin
    int c0, cr;
    nChk = 0; nPass = 0; cyc = 0; chkEn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mOv[d] = 1'b0; mOd[d] = '0; vIn[d] = '0; dIn[d] = '0;
    end

    // Reset with random inputs for two cycles
    rst = 1'b1; rB = 1'($urandom); vEn = 4'($urandom);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) srcQ[d][i].push_back(8'($urandom));
    tick();
    chkEn = 1'b1;
    rB = 1'($urandom); vEn = 4'($urandom);
    tick();
    rst = 1'b0; clearSrc(); vEn = 4'h0; rB = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 32'(vldLog[d][2]), 32'd0);
      chk("reset_data", datLog[d][2], 32'd0);
      chk("reset_ready", 32'(rdyLog[d][2]), 32'hF);
      chk("reset_nobeat", 32'(beatD[d].size()), 32'd0);
    end

    // Aligned stream: lane i sends 16*i+n, n=0..7
    clearLogs(); c0 = cyc; vEn = 4'hF; rB = 1'b1;
    for (int n = 0; n < 8; n++)
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++) srcQ[d][i].push_back(8'(16*i + n));
    repeat (20) tick();
    for (int d = 0; d < 2; d++) begin
      chk("aligned_count", 32'(beatD[d].size()), 32'd8);
      if (beatD[d].size() == 8) begin
        chk("aligned_beat0", beatD[d][0], 32'h30201000);
        chk("aligned_beat7", beatD[d][7], 32'h37271707);
        for (int n = 0; n < 8; n++) begin
          chk("aligned_data", beatD[d][n], beatOf(0, n));
          chk("aligned_cycle", 32'(beatC[d][n]), 32'(c0 + 2 + n*(d+1)));
        end
      end
    end

    // Skew: lane 3 arrives 5 cycles after the others
    clearLogs(); c0 = cyc;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) srcQ[d][i].push_back(8'(8'hA0 + i));
    for (int k = 0; k < 12; k++) begin
      vEn = (k < 5) ? 4'b0111 : 4'hF;
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      for (int k = 1; k <= 5; k++) chk("skew_ready_low", 32'(rdyLog[d][c0+k][2:0]), 32'd0);
      chk("skew_count", 32'(beatD[d].size()), 32'd1);
      if (beatD[d].size() == 1) begin
        chk("skew_data", beatD[d][0], 32'hA3A2A1A0);
        chk("skew_cycle", 32'(beatC[d][0]), 32'(c0 + 7));
      end
    end

    // Backpressure: output stalled for 10 cycles under continuous input
    clearLogs(); c0 = cyc; vEn = 4'hF; rB = 1'b0;
    for (int n = 0; n < 12; n++)
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++) srcQ[d][i].push_back(8'(16*i + n));
    repeat (10) tick();
    for (int d = 0; d < 2; d++) begin
      chk("bp_ready_low", 32'(rdyLog[d][c0+5]), 32'd0);
      chk("bp_held_valid", 32'(vldLog[d][c0+9]), 32'd1);
      chk("bp_held_first", datLog[d][c0+2], 32'h30201000);
      chk("bp_held_last", datLog[d][c0+9], 32'h30201000);
    end
    drain(200);
    for (int d = 0; d < 2; d++) begin
      chk("bp_count", 32'(beatD[d].size()), 32'd12);
      for (int n = 0; n < 12 && n < beatD[d].size(); n++)
        chk("bp_order", beatD[d][n], beatOf(0, n));
    end

    // Randomized traffic: random lane valids and output ready
    clearLogs();
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < NRND; n++) begin
        sent[i][n] = 8'($urandom);
        for (int d = 0; d < 2; d++) srcQ[d][i].push_back(sent[i][n]);
      end
    for (int k = 0; k < 300; k++) begin
      vEn = 4'($urandom);
      rB  = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(1500);
    for (int d = 0; d < 2; d++) begin
      chk("rand_count", 32'(beatD[d].size()), 32'(NRND));
      for (int n = 0; n < NRND && n < beatD[d].size(); n++)
        for (int i = 0; i < 4; i++)
          chk("rand_lane_word", 32'(beatD[d][n][i*8 +: 8]), 32'(sent[i][n]));
    end

    // Mid-operation reset with a held beat and two full lanes
    clearLogs(); vEn = 4'hF; rB = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) srcQ[d][i].push_back(8'(8'h70 + i));
    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      srcQ[d][0].push_back(8'h80);
      srcQ[d][1].push_back(8'h81);
    end
    repeat (3) tick();
    cr = cyc;
    rst = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) srcQ[d][i].push_back(8'hEE);
    tick();
    rst = 1'b0; clearSrc(); clearLogs();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("mrst_valid_before", 32'(vldLog[d][cr]), 32'd1);
      chk("mrst_valid_after", 32'(vldLog[d][cr+1]), 32'd0);
    end
    rB = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) srcQ[d][i].push_back(8'(8'hC0 + i));
    repeat (6) tick();
    for (int d = 0; d < 2; d++) begin
      chk("mrst_count", 32'(beatD[d].size()), 32'd1);
      if (beatD[d].size() == 1) chk("mrst_data", beatD[d][0], 32'hC3C2C1C0);
    end

    chkEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
